mesm6_bus_arbiter: RTL

//  Sits directly downstream of mesm6_core: merges its instruction bus (ibus_*) and data bus (dbus_*)

---
 rtl/mesm6_pkg.sv | 16 +
 rtl/mesm6_prefetch_buf.sv | 69 ++++++
 rtl/mesm6_bus_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mesm6_pkg.sv
// Shared types and default widths for the mesm6 memory-side blocks.
package mesm6_pkg;

  localparam int MESM6_ADDR_W = 15;
  localparam int MESM6_DATA_W = 48;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IFETCH = 3'd1,
    ST_DREAD  = 3'd2,
    ST_DWRITE = 3'd3,
    ST_PREF   = 3'd4,
    ST_RESP   = 3'd5
  } arb_state_t;

endpackage

// File: rtl/mesm6_prefetch_buf.sv
// One-word instruction prefetch buffer: address/data/valid, hit compare, invalidate.
// Used by mesm6_bus_arbiter only when MESM6_IBUS_PREFETCH_EN is defined.
module mesm6_prefetch_buf
  import mesm6_pkg::*;
#(
  parameter int ADDR_W = MESM6_ADDR_W,
  parameter int DATA_W = MESM6_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic              fill_done,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inval,
  input  logic [ADDR_W-1:0] inval_addr,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] rdata
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              kill_q, kill_d;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    if (fill_start) begin
      addr_d  = fill_addr;
      valid_d = 1'b0;
      busy_d  = 1'b1;
    end
    if (fill_done && busy_q) begin
      data_d  = fill_data;
      valid_d = !kill_q;
      busy_d  = 1'b0;
    end
    // A write to the buffered address must also poison a fill still in flight.
    if (inval && (inval_addr == addr_q)) valid_d = 1'b0;
    kill_d = busy_d && !fill_start &&
             (kill_q || (inval && (inval_addr == addr_q)));
  end

  // NOTE: the data word is reset along with the rest; it is one register, not a RAM array.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      kill_q  <= kill_d;
    end
  end

  assign hit   = valid_q && (lookup_addr == addr_q);
  assign rdata = data_q;

endmodule

// File: rtl/mesm6_bus_arbiter.sv
// Merges the mesm6 instruction and data buses onto one single-ported memory.
// Optional next-word instruction prefetch is enabled by MESM6_IBUS_PREFETCH_EN.
module mesm6_bus_arbiter
  import mesm6_pkg::*;
#(
  parameter int ADDR_W = MESM6_ADDR_W,
  parameter int DATA_W = MESM6_DATA_W,
  parameter int DPRIO  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ibus_fetch,
  input  logic [ADDR_W-1:0] ibus_addr,
  output logic [DATA_W-1:0] ibus_input,
  output logic              ibus_done,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [DATA_W-1:0] dbus_output,
  output logic [DATA_W-1:0] dbus_input,
  output logic              dbus_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] ibus_input_q, ibus_input_d;
  logic [DATA_W-1:0] dbus_input_q, dbus_input_d;
  logic              ibus_done_q, ibus_done_d;
  logic              dbus_done_q, dbus_done_d;
  logic              data_first;

`ifdef MESM6_IBUS_PREFETCH_EN
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              pref_pend_q, pref_pend_d;
  logic              hit_q, hit_d;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;

  mesm6_prefetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pbuf (
    .clk         (clk),
    .reset_n     (reset_n),
    .fill_start  (state_q == ST_IDLE && state_d == ST_PREF),
    .fill_addr   (mem_addr_d),
    .fill_done   (state_q == ST_PREF && mem_ack),
    .fill_data   (mem_rdata),
    .inval       (state_q == ST_IDLE && state_d == ST_DWRITE),
    .inval_addr  (dbus_addr),
    .lookup_addr (ibus_addr),
    .hit         (buf_hit),
    .rdata       (buf_data)
  );
`endif

  // NOTE: every *_d gets its hold value first, so no branch can leave one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ibus_input_d = ibus_input_q;
    dbus_input_d = dbus_input_q;
    ibus_done_d  = 1'b0;
    dbus_done_d  = 1'b0;
    data_first   = (DPRIO != 0) || !ibus_fetch;
`ifdef MESM6_IBUS_PREFETCH_EN
    fetch_addr_d = fetch_addr_q;
    pref_pend_d  = pref_pend_q;
    hit_d        = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if ((dbus_read || dbus_write) && data_first) begin
          // Read and write together is served as a write.
          state_d    = dbus_write ? ST_DWRITE : ST_DREAD;
          mem_req_d  = 1'b1;
          mem_we_d   = dbus_write;
          mem_addr_d = dbus_addr;
          if (dbus_write) mem_wdata_d = dbus_output;
`ifdef MESM6_IBUS_PREFETCH_EN
          pref_pend_d = 1'b0;
`endif
        end else if (ibus_fetch) begin
          state_d = ST_IFETCH;
`ifdef MESM6_IBUS_PREFETCH_EN
          fetch_addr_d = ibus_addr;
          pref_pend_d  = 1'b0;
          hit_d        = buf_hit;
          if (!buf_hit) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = ibus_addr;
          end
`else
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = ibus_addr;
`endif
        end
`ifdef MESM6_IBUS_PREFETCH_EN
        else if (pref_pend_q) begin
          state_d     = ST_PREF;
          pref_pend_d = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = fetch_addr_q + ADDR_W'(1);
        end
`endif
      end
      ST_IFETCH: begin
`ifdef MESM6_IBUS_PREFETCH_EN
        // A buffer hit spends this cycle reading the buffer instead of memory.
        if (hit_q) begin
          state_d      = ST_RESP;
          ibus_input_d = buf_data;
          ibus_done_d  = 1'b1;
          pref_pend_d  = 1'b1;
        end else
`endif
        if (mem_ack) begin
          state_d      = ST_RESP;
          mem_req_d    = 1'b0;
          ibus_input_d = mem_rdata;
          ibus_done_d  = 1'b1;
`ifdef MESM6_IBUS_PREFETCH_EN
          pref_pend_d  = 1'b1;
`endif
        end
      end
      ST_DREAD: begin
        if (mem_ack) begin
          state_d      = ST_RESP;
          mem_req_d    = 1'b0;
          dbus_input_d = mem_rdata;
          dbus_done_d  = 1'b1;
        end
      end
      ST_DWRITE: begin
        if (mem_ack) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          dbus_done_d = 1'b1;
        end
      end
`ifdef MESM6_IBUS_PREFETCH_EN
      ST_PREF: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ibus_input_q <= '0;
      dbus_input_q <= '0;
      ibus_done_q  <= 1'b0;
      dbus_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ibus_input_q <= ibus_input_d;
      dbus_input_q <= dbus_input_d;
      ibus_done_q  <= ibus_done_d;
      dbus_done_q  <= dbus_done_d;
    end
  end

`ifdef MESM6_IBUS_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_addr_q <= '0;
      pref_pend_q  <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      pref_pend_q  <= pref_pend_d;
      hit_q        <= hit_d;
    end
  end
`endif

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign ibus_input = ibus_input_q;
  assign dbus_input = dbus_input_q;
  assign ibus_done  = ibus_done_q;
  assign dbus_done  = dbus_done_q;

endmodule
